// File: rtl/mem_cmd_pkg.sv
// Shared constants for the memory command engine: opcodes, response bytes
// and the state encoding used by mem_cmd_engine.
package mem_cmd_pkg;

    // Command opcodes. All eight bits must match exactly.
    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_FILL  = 8'h03;
    localparam logic [7:0] OP_PING  = 8'h04;

    // Response bytes sent back over the transmitter.
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;
    localparam logic [7:0] RSP_PING = 8'hA5;

    // Engine state encoding.
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_HDR       = 4'd1;
    localparam logic [3:0] ST_RD_ISSUE  = 4'd2;
    localparam logic [3:0] ST_RD_WAIT   = 4'd3;
    localparam logic [3:0] ST_RD_SEND   = 4'd4;
    localparam logic [3:0] ST_WR_DATA   = 4'd5;
    localparam logic [3:0] ST_FILL_DATA = 4'd6;
    localparam logic [3:0] ST_FILL_LOOP = 4'd7;
    localparam logic [3:0] ST_RESP      = 4'd8;

endpackage

// File: rtl/rx_watchdog.sv
// Inter-byte watchdog. Counts enabled cycles without a clear; expire is high
// in the TIMEOUT-th consecutive idle cycle so the engine can abort the frame.
module rx_watchdog #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Idle-cycle counter, held at zero while disabled or on every received byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || clr) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = en && !clr && (cnt == LIMIT);

endmodule

// File: rtl/mem_cmd_engine.sv
// Byte-stream memory command engine. Parses opcode/length/address frames from
// a receiver, performs READ/WRITE/FILL/PING against a synchronous memory and
// returns data or status bytes through a transmitter handshake.
module mem_cmd_engine
    import mem_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_opcode
);

    localparam int unsigned HDR_W     = LEN_W + ADDR_W;
    localparam int unsigned HDR_BYTES = HDR_W / 8;
    localparam int unsigned HCNT_W    = (HDR_BYTES < 2) ? 1 : $clog2(HDR_BYTES);
    localparam logic [HCNT_W-1:0] HDR_LAST = HCNT_W'(HDR_BYTES - 1);
    localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

    logic [3:0]        state;
    logic [7:0]        opcode;
    logic [HDR_W-9:0]  hdr_sr;
    logic [HCNT_W-1:0] hdr_cnt;
    logic [LEN_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        fill_byte;
    logic [7:0]        resp_byte;
    logic [1:0]        wait_cnt;
    logic              tx_start_q;
    logic              tx_ready;
    logic              wd_en;
    logic              wd_expire;
    logic [HDR_W-1:0]  hdr_full;

    // Header bytes arrive MSB first; the last byte completes length and address.
    assign hdr_full = {hdr_sr, rx_data};

    // Transmitter free: not busy and no start issued this or the previous cycle,
    // covering the gap before the transmitter reflects a fresh start in tx_busy.
    assign tx_ready = !tx_busy && !tx_start && !tx_start_q;

    assign busy  = (state != ST_IDLE);
    assign wd_en = (state == ST_HDR) || (state == ST_WR_DATA) || (state == ST_FILL_DATA);

    rx_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_rx_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (wd_en),
        .clr    (rx_valid),
        .expire (wd_expire)
    );

    // Frame sequencing, memory strobes and transmitter handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            opcode      <= '0;
            hdr_sr      <= '0;
            hdr_cnt     <= '0;
            cnt         <= '0;
            addr        <= '0;
            fill_byte   <= '0;
            resp_byte   <= '0;
            wait_cnt    <= '0;
            tx_start_q  <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            err_timeout <= 1'b0;
            err_opcode  <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            err_timeout <= 1'b0;
            err_opcode  <= 1'b0;
            tx_start_q  <= tx_start;

            case (state)
                ST_IDLE: begin
                    hdr_cnt <= '0;
                    if (rx_valid) begin
                        opcode <= rx_data;
                        if (rx_data == OP_PING) begin
                            resp_byte <= RSP_PING;
                            state     <= ST_RESP;
                        end else begin
                            state <= ST_HDR;
                        end
                    end
                end

                ST_HDR: begin
                    if (wd_expire) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (rx_valid) begin
                        if (hdr_cnt == HDR_LAST) begin
                            cnt  <= hdr_full[ADDR_W +: LEN_W];
                            addr <= hdr_full[ADDR_W-1:0];
                            case (opcode)
                                OP_READ:  state <= ST_RD_ISSUE;
                                OP_WRITE: state <= ST_WR_DATA;
                                OP_FILL:  state <= ST_FILL_DATA;
                                default: begin
                                    err_opcode <= 1'b1;
                                    resp_byte  <= RSP_NAK;
                                    state      <= ST_RESP;
                                end
                            endcase
                        end else begin
                            hdr_sr  <= hdr_full[HDR_W-9:0];
                            hdr_cnt <= hdr_cnt + HCNT_W'(1);
                        end
                    end
                end

                ST_RD_ISSUE: begin
                    if (tx_ready) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= addr;
                        wait_cnt <= WAIT_INIT;
                        state    <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= ST_RD_SEND;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end

                ST_RD_SEND: begin
                    tx_data  <= mem_rdata;
                    tx_start <= 1'b1;
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt   <= cnt - LEN_W'(1);
                        addr  <= addr + ADDR_W'(1);
                        state <= ST_RD_ISSUE;
                    end
                end

                ST_WR_DATA: begin
                    if (wd_expire) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (rx_valid) begin
                        mem_wr    <= 1'b1;
                        mem_wdata <= rx_data;
                        mem_addr  <= addr;
                        addr      <= addr + ADDR_W'(1);
                        if (cnt == '0) begin
                            resp_byte <= RSP_ACK;
                            state     <= ST_RESP;
                        end else begin
                            cnt <= cnt - LEN_W'(1);
                        end
                    end
                end

                ST_FILL_DATA: begin
                    if (wd_expire) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (rx_valid) begin
                        fill_byte <= rx_data;
                        state     <= ST_FILL_LOOP;
                    end
                end

                ST_FILL_LOOP: begin
                    mem_wr    <= 1'b1;
                    mem_wdata <= fill_byte;
                    mem_addr  <= addr;
                    addr      <= addr + ADDR_W'(1);
                    if (cnt == '0) begin
                        resp_byte <= RSP_ACK;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - LEN_W'(1);
                    end
                end

                ST_RESP: begin
                    if (tx_ready) begin
                        tx_data  <= resp_byte;
                        tx_start <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_cmd_engine.sv
// Randomized self-checking bench for mem_cmd_engine with a frame-level
// reference model, a latency-accurate memory and a busy-holding transmitter.
module tb_mem_cmd_engine;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned TMO    = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        err_timeout;
    logic        err_opcode;

    always #5 clk = ~clk;

    mem_cmd_engine #(
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .RD_LATENCY (RD_LAT),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_opcode  (err_opcode)
    );

    function automatic logic [7:0] init_val(input int unsigned a);
        return 8'(a ^ (a >> 8) ^ 32'h3C);
    endfunction

    // ---------------- environment (memory, transmitter, monitor) ----------
    logic [7:0]  ram [0:65535];
    logic        ram_ready = 1'b0;
    logic [7:0]  rd_pipe [0:RD_LAT];
    int unsigned busy_left = 0;
    int unsigned wr_count = 0, rd_count = 0, wr_run = 0, last_run = 0;
    int unsigned to_count = 0, op_count = 0, viol_tx = 0, viol_both = 0;
    int unsigned tx_count = 0;
    logic [7:0]  tx_log [0:4095];

    assign mem_rdata = rd_pipe[RD_LAT];
    assign tx_busy   = (busy_left != 0);

    always @(negedge clk) begin
        if (!ram_ready) begin
            for (int unsigned i = 0; i < 65536; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end
        if (mem_wr) begin
            ram[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
            wr_run   <= wr_run + 1;
        end else begin
            if (wr_run != 0) last_run <= wr_run;
            wr_run <= 0;
        end
        for (int unsigned i = RD_LAT; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= mem_rd ? ram[mem_addr] : 8'($urandom);
        if (mem_rd) rd_count <= rd_count + 1;
        if (mem_rd && mem_wr) viol_both <= viol_both + 1;
        if (err_timeout) to_count <= to_count + 1;
        if (err_opcode) op_count <= op_count + 1;
        if (tx_start) begin
            if (tx_busy) viol_tx <= viol_tx + 1;
            tx_log[tx_count % 4096] <= tx_data;
            tx_count  <= tx_count + 1;
            busy_left <= $urandom_range(1, 6);
        end else if (busy_left != 0) begin
            busy_left <= busy_left - 1;
        end
    end

    // ---------------- reference model state and checker -------------------
    logic [7:0]  ref_mem [0:65535];
    logic [7:0]  exp_tx [$];
    int unsigned touched [$];
    int unsigned exp_wr = 0, exp_rd = 0, exp_to = 0, exp_op = 0, tx_seen = 0;
    int unsigned n_vec = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle"}, 64'(busy), 64'd0);
        repeat (12) @(negedge clk);
    endtask

    task automatic check_frame(input string tag);
        check_eq({tag, "_txn"}, 64'(tx_count - tx_seen), 64'(exp_tx.size()));
        for (int unsigned i = 0; i < exp_tx.size() && tx_seen + i < tx_count; i++)
            check_eq({tag, "_tx"}, 64'(tx_log[(tx_seen + i) % 4096]), 64'(exp_tx[i]));
        tx_seen = tx_count;
        exp_tx.delete();
        check_eq({tag, "_wr"}, 64'(wr_count), 64'(exp_wr));
        check_eq({tag, "_rd"}, 64'(rd_count), 64'(exp_rd));
        check_eq({tag, "_to"}, 64'(to_count), 64'(exp_to));
        check_eq({tag, "_op"}, 64'(op_count), 64'(exp_op));
        foreach (touched[i])
            check_eq({tag, "_mem"}, 64'(ram[touched[i]]), 64'(ref_mem[touched[i]]));
        touched.delete();
    endtask

    // Build one frame, update the model from the command's meaning, drive it.
    task automatic run_frame(input string tag, input logic [7:0] op, input int unsigned len,
                             input logic [15:0] addr, input bit fixed, input logic [7:0] d0,
                             input int unsigned gap_max);
        logic [7:0]  bytes [$];
        logic [7:0]  d;
        logic [15:0] a;
        bytes.push_back(op);
        if (op != 8'h04) begin
            bytes.push_back(8'(len));
            bytes.push_back(addr[15:8]);
            bytes.push_back(addr[7:0]);
        end
        case (op)
            8'h04: exp_tx.push_back(8'hA5);
            8'h01: begin
                for (int unsigned i = 0; i <= len; i++) begin
                    a = addr + 16'(i);
                    exp_tx.push_back(ref_mem[a]);
                end
                exp_rd += len + 1;
            end
            8'h02: begin
                for (int unsigned i = 0; i <= len; i++) begin
                    a = addr + 16'(i);
                    d = fixed ? 8'(d0 + 8'h11 * i) : 8'($urandom);
                    bytes.push_back(d);
                    ref_mem[a] = d;
                    touched.push_back(32'(a));
                end
                exp_wr += len + 1;
                exp_tx.push_back(8'h06);
            end
            8'h03: begin
                d = fixed ? d0 : 8'($urandom);
                bytes.push_back(d);
                for (int unsigned i = 0; i <= len; i++) begin
                    a = addr + 16'(i);
                    ref_mem[a] = d;
                    touched.push_back(32'(a));
                end
                exp_wr += len + 1;
                exp_tx.push_back(8'h06);
            end
            default: begin
                exp_op++;
                exp_tx.push_back(8'h15);
            end
        endcase
        foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, gap_max));
        wait_idle(tag);
        if (op == 8'h03) check_eq({tag, "_run"}, 64'(last_run), 64'(len + 1));
        check_frame(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  op;
        logic [15:0] ra;
        int unsigned k, ln;
        for (int unsigned i = 0; i < 65536; i++) ref_mem[i] = init_val(i);

        #2;
        check_eq("reset_outputs",
                 {tx_start, mem_rd, mem_wr, busy, err_timeout, err_opcode, tx_data, mem_addr, mem_wdata},
                 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_frame("write4", 8'h02, 3, 16'h1234, 1'b1, 8'hAA, 2);
        run_frame("pre_ffff", 8'h02, 0, 16'hFFFF, 1'b1, 8'h11, 1);
        run_frame("pre_0000", 8'h02, 0, 16'h0000, 1'b1, 8'h22, 1);
        run_frame("read_wrap", 8'h01, 1, 16'hFFFF, 1'b0, 8'h00, 2);
        run_frame("fill256", 8'h03, 255, 16'h0000, 1'b1, 8'h5A, 1);
        run_frame("bad_op", 8'h7E, 0, 16'h0000, 1'b0, 8'h00, 2);

        // Exactly TIMEOUT idle cycles after a header byte aborts the frame.
        send_byte(8'h02, 0);
        send_byte(8'h00, TMO - 1);
        exp_to++;
        wait_idle("timeout");
        check_frame("timeout");
        run_frame("ping", 8'h04, 0, 16'h0000, 1'b0, 8'h00, 0);

        // One cycle short of the limit between bytes must still complete.
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        send_byte(8'h00, TMO - 2);
        send_byte(8'h77, 0);
        ref_mem[16'h4000] = 8'h77;
        touched.push_back(32'h4000);
        exp_wr++;
        exp_tx.push_back(8'h06);
        wait_idle("gap_edge");
        check_frame("gap_edge");

        // Reset in the middle of a multi-byte read.
        send_byte(8'h01, 0);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midread_reset",
                 {tx_start, mem_rd, mem_wr, busy, err_timeout, err_opcode, tx_data, mem_addr, mem_wdata},
                 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        tx_seen = tx_count;
        exp_rd  = rd_count;
        exp_tx.delete();
        run_frame("read_after_rst", 8'h01, 2, 16'h0010, 1'b0, 8'h00, 1);

        for (int unsigned n = 0; n < 40; n++) begin
            k  = $urandom_range(0, 9);
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
            ln = $urandom_range(0, 7);
            if (k <= 2) op = 8'h01;
            else if (k <= 5) op = 8'h02;
            else if (k <= 7) begin
                op = 8'h03;
                ln = $urandom_range(0, 20);
            end else if (k == 8) op = 8'h04;
            else begin
                op = 8'($urandom);
                while (op >= 8'h01 && op <= 8'h04) op = 8'($urandom);
            end
            run_frame("rand", op, ln, ra, 1'b0, 8'h00, 3);
        end

        check_eq("tx_while_busy", 64'(viol_tx), 64'd0);
        check_eq("rd_wr_overlap", 64'(viol_both), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
